// File: rtl/isp_dpc_ctrl.sv
// Frame-synchronous config/monitor controller for the defective-pixel-correction stage.
// Host writes land in shadow registers and are committed to the datapath on in_vsync rising edges.
module isp_dpc_ctrl #(
   parameter int BITS          = 8,
   parameter int WIDTH         = 1280,
   parameter int HEIGHT        = 960,
   parameter int DEF_THRESHOLD = 40
) (
   input  logic            pclk,
   input  logic            rst_n,
   input  logic            in_href,
   input  logic            in_vsync,
   input  logic            reg_wr,
   input  logic            reg_rd,
   input  logic [1:0]      reg_addr,
   input  logic [15:0]     reg_wdata,
   output logic [15:0]     reg_rdata,
   output logic            reg_rvalid,
   output logic            dpc_enable,
   output logic [BITS-1:0] dpc_threshold,
   output logic            frame_start,
   output logic            irq
);

   logic            vsync_q, vsync_d, href_q, href_d;
   logic [15:0]     pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d, frame_cnt_q, frame_cnt_d;
   logic            len_err_q, len_err_d, cnt_err_q, cnt_err_d, pending_q, pending_d;
   logic            en_sh_q, en_sh_d, irq_en_q, irq_en_d;
   logic [BITS-1:0] thr_sh_q, thr_sh_d, dpc_threshold_q, dpc_threshold_d;
   logic            dpc_enable_q, dpc_enable_d, frame_start_q, frame_start_d, irq_q, irq_d;
   logic [15:0]     reg_rdata_q, reg_rdata_d;
   logic            reg_rvalid_q, reg_rvalid_d;
   logic            vs_rise, href_fall, wr_ctrl, wr_thr, wr_stat, len_set, cnt_set;

   // Only the low BITS bits of a THRESH write are meaningful.
   wire unused_wdata = ^reg_wdata;

   always_comb begin
      vs_rise   = in_vsync & ~vsync_q;
      href_fall = href_q & ~in_href;
      wr_ctrl   = reg_wr && (reg_addr == 2'd0);
      wr_thr    = reg_wr && (reg_addr == 2'd1);
      wr_stat   = reg_wr && (reg_addr == 2'd2);

      vsync_d         = in_vsync;
      href_d          = in_href;
      pix_cnt_d       = pix_cnt_q;
      line_cnt_d      = line_cnt_q;
      frame_cnt_d     = frame_cnt_q;
      en_sh_d         = en_sh_q;
      irq_en_d        = irq_en_q;
      thr_sh_d        = thr_sh_q;
      pending_d       = pending_q;
      dpc_enable_d    = dpc_enable_q;
      dpc_threshold_d = dpc_threshold_q;
      reg_rdata_d     = reg_rdata_q;

      if (in_href && pix_cnt_q != 16'hFFFF) pix_cnt_d = pix_cnt_q + 16'd1;
      if (href_fall) begin
         pix_cnt_d = 16'd0;
         if (line_cnt_q != 16'hFFFF) line_cnt_d = line_cnt_q + 16'd1;
      end
      if (vs_rise && line_cnt_q != 16'd0) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
         line_cnt_d  = 16'd0;
      end

      // Set events override a simultaneous write-1-to-clear.
      len_set   = href_fall && (pix_cnt_q != 16'(WIDTH));
      cnt_set   = vs_rise && (line_cnt_q != 16'd0) && (line_cnt_q != 16'(HEIGHT));
      len_err_d = len_set | (len_err_q & ~(wr_stat & reg_wdata[0]));
      cnt_err_d = cnt_set | (cnt_err_q & ~(wr_stat & reg_wdata[1]));

      // Commit reads the pre-write shadow; a coincident write re-arms pending.
      if (vs_rise && pending_q) begin
         dpc_enable_d    = en_sh_q;
         dpc_threshold_d = thr_sh_q;
         pending_d       = 1'b0;
      end
      if (wr_ctrl) begin
         en_sh_d  = reg_wdata[0];
         irq_en_d = reg_wdata[1];
      end
      if (wr_thr) thr_sh_d = reg_wdata[BITS-1:0];
      if (wr_ctrl || wr_thr) pending_d = 1'b1;

      frame_start_d = vs_rise;
      irq_d         = irq_en_q & (len_err_q | cnt_err_q);

      reg_rvalid_d = reg_rd;
      if (reg_rd) begin
         case (reg_addr)
            2'd0:    reg_rdata_d = {14'd0, irq_en_q, en_sh_q};
            2'd1:    reg_rdata_d = 16'(thr_sh_q);
            2'd2:    reg_rdata_d = {13'd0, pending_q, cnt_err_q, len_err_q};
            default: reg_rdata_d = frame_cnt_q;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_q         <= 1'b0;
         href_q          <= 1'b0;
         pix_cnt_q       <= 16'd0;
         line_cnt_q      <= 16'd0;
         frame_cnt_q     <= 16'd0;
         len_err_q       <= 1'b0;
         cnt_err_q       <= 1'b0;
         pending_q       <= 1'b0;
         en_sh_q         <= 1'b0;
         irq_en_q        <= 1'b0;
         thr_sh_q        <= BITS'(DEF_THRESHOLD);
         dpc_enable_q    <= 1'b0;
         dpc_threshold_q <= BITS'(DEF_THRESHOLD);
         frame_start_q   <= 1'b0;
         irq_q           <= 1'b0;
         reg_rdata_q     <= 16'd0;
         reg_rvalid_q    <= 1'b0;
      end else begin
         vsync_q         <= vsync_d;
         href_q          <= href_d;
         pix_cnt_q       <= pix_cnt_d;
         line_cnt_q      <= line_cnt_d;
         frame_cnt_q     <= frame_cnt_d;
         len_err_q       <= len_err_d;
         cnt_err_q       <= cnt_err_d;
         pending_q       <= pending_d;
         en_sh_q         <= en_sh_d;
         irq_en_q        <= irq_en_d;
         thr_sh_q        <= thr_sh_d;
         dpc_enable_q    <= dpc_enable_d;
         dpc_threshold_q <= dpc_threshold_d;
         frame_start_q   <= frame_start_d;
         irq_q           <= irq_d;
         reg_rdata_q     <= reg_rdata_d;
         reg_rvalid_q    <= reg_rvalid_d;
      end
   end

   assign reg_rdata     = reg_rdata_q;
   assign reg_rvalid    = reg_rvalid_q;
   assign dpc_enable    = dpc_enable_q;
   assign dpc_threshold = dpc_threshold_q;
   assign frame_start   = frame_start_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_isp_dpc_ctrl.sv
// Randomized bench for isp_dpc_ctrl against a frame/line-level reference model.
module tb_isp_dpc_ctrl;
   localparam int BITS = 8, W = 16, H = 4, DEFT = 40;

   logic        pclk = 1'b0, rst_n = 1'b0;
   logic        in_href = 1'b0, in_vsync = 1'b0, reg_wr = 1'b0, reg_rd = 1'b0;
   logic [1:0]  reg_addr = 2'd0;
   logic [15:0] reg_wdata = 16'd0;
   logic [15:0] reg_rdata;
   logic        reg_rvalid, dpc_enable, frame_start, irq;
   logic [BITS-1:0] dpc_threshold;

   isp_dpc_ctrl #(.BITS(BITS), .WIDTH(W), .HEIGHT(H), .DEF_THRESHOLD(DEFT)) dut (
      .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .dpc_enable(dpc_enable),
      .dpc_threshold(dpc_threshold), .frame_start(frame_start), .irq(irq));

   always #5 pclk = ~pclk;

   int n_tests = 0, n_fail = 0;

   // Reference model: shadow/active config, sticky flags, frame counter, lines this frame.
   bit          m_en_sh, m_irqen, m_en, m_pend, m_lle, m_lce;
   logic [7:0]  m_th_sh, m_th;
   logic [15:0] m_fcnt;
   int          m_lines;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic model_reset();
      m_en_sh = 0; m_irqen = 0; m_en = 0; m_pend = 0; m_lle = 0; m_lce = 0;
      m_th_sh = 8'(DEFT); m_th = 8'(DEFT); m_fcnt = 16'd0; m_lines = 0;
   endtask

   task automatic model_write(input logic [1:0] a, input logic [15:0] d);
      case (a)
         2'd0: begin m_en_sh = d[0]; m_irqen = d[1]; m_pend = 1; end
         2'd1: begin m_th_sh = d[7:0]; m_pend = 1; end
         2'd2: begin if (d[0]) m_lle = 0; if (d[1]) m_lce = 0; end
         default: ;
      endcase
   endtask

   function automatic logic [15:0] m_reg(input logic [1:0] a);
      case (a)
         2'd0:    return {14'd0, m_irqen, m_en_sh};
         2'd1:    return {8'd0, m_th_sh};
         2'd2:    return {13'd0, m_pend, m_lce, m_lle};
         default: return m_fcnt;
      endcase
   endfunction

   function automatic bit m_irq();
      return m_irqen & (m_lle | m_lce);
   endfunction

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      reg_wr = 1; reg_addr = a; reg_wdata = d;
      tick();
      reg_wr = 0;
      model_write(a, d);
   endtask

   task automatic rd(input logic [1:0] a, input string tag);
      logic [15:0] exp;
      exp = m_reg(a);
      reg_rd = 1; reg_addr = a;
      tick();
      reg_rd = 0;
      chk({tag, "_rvalid"}, reg_rvalid, 1);
      chk(tag, reg_rdata, exp);
      tick();
      chk({tag, "_rvalid_low"}, reg_rvalid, 0);
      chk({tag, "_hold"}, reg_rdata, exp);
   endtask

   task automatic check_all(input string tag);
      rd(2'd0, {tag, "_ctrl"});
      rd(2'd1, {tag, "_thresh"});
      rd(2'd2, {tag, "_status"});
      rd(2'd3, {tag, "_fcnt"});
      chk({tag, "_irq"}, irq, m_irq());
      chk({tag, "_en"}, dpc_enable, m_en);
      chk({tag, "_th"}, dpc_threshold, m_th);
   endtask

   // One line of n pixels; optionally a STATUS clear-all write lands on the href_fall cycle.
   task automatic line(input int n, input bit clr_on_fall);
      bit irq_before;
      in_href = 1;
      repeat (n) tick();
      in_href = 0;
      if (clr_on_fall) begin reg_wr = 1; reg_addr = 2'd2; reg_wdata = 16'h3; end
      irq_before = m_irq();
      tick();
      reg_wr = 0;
      if (clr_on_fall) model_write(2'd2, 16'h3);
      m_lines++;
      if (n != W) m_lle = 1;
      chk("irq_lag", irq, irq_before);
      tick();
      chk("irq_line", irq, m_irq());
   endtask

   task automatic vframe(input bit do_wr, input logic [15:0] wd);
      in_vsync = 1;
      if (do_wr) begin reg_wr = 1; reg_addr = 2'd1; reg_wdata = wd; end
      tick();
      reg_wr = 0;
      if (m_pend) begin m_en = m_en_sh; m_th = m_th_sh; m_pend = 0; end
      if (m_lines > 0) begin
         if (m_lines != H) m_lce = 1;
         m_fcnt = m_fcnt + 16'd1;
         m_lines = 0;
      end
      if (do_wr) model_write(2'd1, wd);
      chk("frame_start", frame_start, 1);
      chk("commit_en", dpc_enable, m_en);
      chk("commit_th", dpc_threshold, m_th);
      tick();
      chk("frame_start_pulse", frame_start, 0);
      in_vsync = 0;
      tick();
   endtask

   initial begin
      model_reset();
      #22;
      chk("rst_en", dpc_enable, 0);
      chk("rst_th", dpc_threshold, DEFT);
      chk("rst_irq", irq, 0);
      chk("rst_rvalid", reg_rvalid, 0);
      rst_n = 1;
      tick();
      check_all("reset");

      // Mid-frame shadow writes stay invisible until the frame boundary.
      vframe(0, 16'h0);
      line(W, 0); line(W, 0);
      wr(2'd1, 16'hFF20);
      wr(2'd0, 16'h0001);
      check_all("pending");
      line(W, 0); line(W, 0);
      vframe(0, 16'h0);
      check_all("committed");

      // Short line raises line_len_err and irq; clear and run clean frames.
      wr(2'd0, 16'h0003);
      vframe(0, 16'h0);
      line(W, 0); line(W, 0); line(W - 1, 0); line(W, 0);
      check_all("len_err");
      vframe(0, 16'h0);
      wr(2'd2, 16'h0001);
      check_all("len_clr");
      repeat (2) begin
         repeat (H) line(W, 0);
         vframe(0, 16'h0);
      end
      check_all("clean");

      // Short frame raises line_cnt_err; an empty frame does not count.
      repeat (3) line(W, 0);
      vframe(0, 16'h0);
      check_all("cnt_err");
      vframe(0, 16'h0);
      check_all("empty_frame");

      // Set wins over a coincident clear.
      line(W + 1, 1);
      check_all("set_wins");
      wr(2'd2, 16'h0003);

      // Threshold write on the exact vs_rise cycle.
      wr(2'd1, 16'h0055);
      repeat (H) line(W, 0);
      vframe(1, 16'h0066);
      check_all("coincident");
      vframe(0, 16'h0);
      check_all("coincident_next");

      // Randomized frames with interleaved writes and reads.
      for (int f = 0; f < 40; f++) begin
         int nl;
         nl = $urandom_range(0, 5);
         for (int l = 0; l < nl; l++) begin
            if ($urandom_range(0, 3) == 0)
               wr(2'($urandom_range(0, 3)), 16'($urandom));
            line(($urandom_range(0, 4) == 0) ? W - 1 + $urandom_range(0, 2) : W,
                 $urandom_range(0, 9) == 0);
         end
         if ($urandom_range(0, 2) == 0) check_all("rand");
         vframe($urandom_range(0, 5) == 0, 16'($urandom));
      end
      check_all("rand_end");

      // Asynchronous reset mid-line.
      wr(2'd0, 16'h0003);
      line(W - 1, 0);
      in_href = 1;
      repeat (3) tick();
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("arst_en", dpc_enable, 0);
      chk("arst_th", dpc_threshold, DEFT);
      chk("arst_irq", irq, 0);
      chk("arst_fs", frame_start, 0);
      chk("arst_rvalid", reg_rvalid, 0);
      chk("arst_rdata", reg_rdata, 0);
      in_href = 0;
      tick();
      rst_n = 1;
      tick();
      check_all("after_rst");
      vframe(0, 16'h0);
      check_all("after_rst_vs");
      repeat (H) line(W, 0);
      vframe(0, 16'h0);
      check_all("after_rst_frame");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/isp_dpc_ctrl.md
Name: isp_dpc_ctrl

Overview:
Frame-synchronous configuration and monitoring controller for the defective-pixel-correction stage.
- Host writes land in shadow registers. They are committed to the DPC datapath only at frame boundaries (in_vsync rising edge), so threshold and enable never change mid-frame.
- The block also measures incoming frame geometry, flags line-length and line-count errors, counts frames, and raises a level interrupt.
- It sits beside the DPC stage, samples the same in_href/in_vsync, and drives the DPC threshold and enable/bypass controls.

Parameters:
BITS, 8, raw pixel width; width of threshold.
WIDTH, 1280, expected in_href-high cycles per line.
HEIGHT, 960, expected lines per frame.
DEF_THRESHOLD, 40, threshold value after reset (active and shadow).

Ports:
pclk  in  1  pixel clock.
rst_n  in  1  reset.
in_href  in  1  line-valid, active high.
in_vsync  in  1  frame sync, active high during vertical blanking.
reg_wr  in  1  register write strobe, one cycle.
reg_rd  in  1  register read strobe, one cycle.
reg_addr  in  2  register address.
reg_wdata  in  16  write data.
reg_rdata  out  16  read data.
reg_rvalid  out  1  read data valid, one-cycle pulse.
dpc_enable  out  1  active enable; 0 = DPC output bypassed.
dpc_threshold  out  BITS  active defect threshold.
frame_start  out  1  one-cycle pulse on in_vsync rising edge.
irq  out  1  level interrupt.

Behaviour:
- Interface:
  - Reset rst_n, asynchronous, active-low; clock pclk.
  - All outputs and state are registered.
- Reset values:
  - reg_rdata=0, reg_rvalid=0, dpc_enable=0, dpc_threshold=DEF_THRESHOLD, frame_start=0, irq=0.
  - Shadow: enable=0, irq_en=0, threshold=DEF_THRESHOLD.
  - pending=0; all counters and sticky bits 0.
- Register map:
  - 0 CTRL: [0] enable, [1] irq_en. Shadow; irq_en takes effect immediately.
  - 1 THRESH: [BITS-1:0] shadow threshold; upper bits ignored.
  - 2 STATUS: [0] line_len_err, [1] line_cnt_err, [2] pending (read-only). Write 1 to clear [1:0].
  - 3 FRAME_CNT: 16-bit frame counter. Read-only; writes ignored.
- Writes and reads:
  - Any write to address 0 or 1 sets pending.
  - Read: reg_rdata and reg_rvalid are updated on the cycle after reg_rd. Reads return shadow values; unused bits read 0.
  - When reg_rd is low, reg_rvalid=0 and reg_rdata holds its last value.
- Edge detect: vs_rise = in_vsync & ~vsync_d; href_fall = href_d & ~in_href, where vsync_d and href_d are registered copies.
- Commit (on vs_rise):
  - frame_start=1 on the cycle after vs_rise.
  - If pending, dpc_enable and dpc_threshold load from shadow on that same cycle, and pending clears.
- Write coincident with vs_rise:
  - The commit uses the shadow value from before the write.
  - The write updates the shadow, and pending remains 1.
- Geometry counters:
  - pix_cnt (16b, saturating) increments every in_href-high cycle.
  - On href_fall: if pix_cnt≠WIDTH, set line_len_err. pix_cnt clears and line_cnt (16b, saturating) increments.
  - On vs_rise with line_cnt>0:
    - If line_cnt≠HEIGHT, set line_cnt_err.
    - FRAME_CNT increments, wrapping 0xFFFF→0.
    - line_cnt clears.
  - vs_rise with line_cnt=0: no check and no FRAME_CNT increment.
- Sticky-bit priority: if a clear-write and a set event coincide on the same cycle, the set wins.
- Interrupt: irq = irq_en & (line_len_err | line_cnt_err), registered with 1-cycle latency.
- Asynchronous reset mid-frame returns everything to reset values. The first vs_rise after release does not increment FRAME_CNT unless href_fall events occurred before it.

Test Plan:
1. Reset, then read all four addresses → CTRL=0, THRESH=40, STATUS=0, FRAME_CNT=0; dpc_enable=0, dpc_threshold=40, irq=0.
2. Mid-frame write THRESH=0x20 and CTRL=1 → outputs unchanged and STATUS[2]=1 until vs_rise. On the cycle after vs_rise: dpc_threshold=0x20, dpc_enable=1, frame_start pulse, STATUS[2]=0.
3. Frame with WIDTH=16, HEIGHT=4 but line 3 only 15 pixels, CTRL=3 → line_len_err=1 after that line, irq=1 one cycle later. Write STATUS=1 → both clear; with correct frames neither sets again.
4. Frame of 3 lines with HEIGHT=4 → line_cnt_err=1 at vs_rise, FRAME_CNT increments. A vs_rise with no lines → FRAME_CNT unchanged.
5. THRESH write on the exact vs_rise cycle → commit loads the old shadow; STATUS[2] stays 1; the new value is applied at the next vs_rise.
6. Assert rst_n low mid-line after several frames → all outputs and registers immediately return to reset values. FRAME_CNT wraps from 0xFFFF to 0 when forced through 65536 frames (shortened with a small-geometry build).
